// File: rtl/truth_table_checker.sv
// truth_table_checker
//
// Sequencer that sweeps every input vector of an N_IN-input combinational
// block, waits a programmable settle time, samples the block's single output
// and compares it with the expected truth table TRUTH (bit i = expected
// output for vector i). Reports pass/fail, number of mismatching vectors and
// the first failing vector.
//
// Parameters:
//   N_IN    number of DUT inputs; vectors run 0 .. 2**N_IN-1
//   TRUTH   expected output per vector (bit i for vector i)
//   SETTLE  extra settle cycles between driving a vector and sampling (>= 0)
//
// Ports:
//   clk               in   clock, rising edge
//   rst_n             in   asynchronous active-low reset
//   start             in   request a sweep; accepted only while busy=0
//   dut_s             in   output of the block under test
//   vec_out           out  vector driven to the block inputs (MSB = a)
//   busy              out  sweep in progress
//   done              out  sweep finished; held until the next accepted start
//   pass              out  valid with done; 1 iff no vector mismatched
//   err_cnt           out  number of mismatching vectors (never wraps)
//   first_fail_valid  out  at least one mismatch recorded
//   first_fail_idx    out  index of the first mismatching vector
//   sample_strobe     out  high for the single compare cycle of each vector
//   mismatch          out  high with sample_strobe when dut_s != TRUTH[idx]
module truth_table_checker #(
    parameter int                      N_IN   = 2,
    parameter logic [(2**N_IN)-1:0]    TRUTH  = 4'b0100,
    parameter int                      SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            dut_s,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_idx,
    output logic            sample_strobe,
    output logic            mismatch
);

    // Counter must be at least one bit wide even when SETTLE is 0.
    localparam int               CNT_W    = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE);
    localparam logic [N_IN-1:0]  IDX_LAST = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [N_IN-1:0]   idx;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              mismatch_c;

    // The driven vector is the sweep index itself, so it holds the last
    // vector while in DONE and clears together with idx on reset.
    assign vec_out = idx;

    // Strobes decode the registered state, so they cover exactly the SAMPLE
    // cycle and drop immediately with the asynchronous reset.
    assign sample_strobe = (state == S_SAMPLE);
    assign mismatch      = mismatch_c;

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        mismatch_c = (state == S_SAMPLE) && (dut_s != TRUTH[idx]);
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                // Terminal check precedes the increment, so idx never wraps.
                state_nxt = (idx == IDX_LAST) ? S_DONE : S_SETTLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            idx              <= '0;
            cnt              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_cnt          <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                idx              <= '0;
                cnt              <= CNT_INIT;
                busy             <= 1'b1;
                done             <= 1'b0;
                pass             <= 1'b0;
                err_cnt          <= '0;
                first_fail_valid <= 1'b0;
                first_fail_idx   <= '0;
            end else if (state == S_SETTLE) begin
                if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end
            end else if (state == S_SAMPLE) begin
                if (mismatch_c) begin
                    err_cnt <= err_cnt + (N_IN+1)'(1);
                    if (!first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_idx   <= idx;
                    end
                end
                if (idx == IDX_LAST) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    // Include the compare happening on this very edge.
                    pass <= (err_cnt == '0) && !mismatch_c;
                end else begin
                    idx <= idx + N_IN'(1);
                    cnt <= CNT_INIT;
                end
            end
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic sel;        // 0: default instance (SETTLE=1), 1: SETTLE=0 instance
    int   mode;       // 0: s=a&~b, 1: s=a|b, 2: stuck-at-1

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic       start0, start1, dut_s0, dut_s1;
    logic [1:0] vec0, vec1, ffi0, ffi1;
    logic [2:0] err0, err1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic       ffv0, ffv1, stb0, stb1, mis0, mis1;

    function automatic logic good_s(input int v);
        logic a, b;
        a = v[1];
        b = v[0];
        return a & ~b;
    endfunction

    function automatic logic dut_fn(input int m, input int v);
        logic a, b;
        a = v[1];
        b = v[0];
        case (m)
            1:       return a | b;
            2:       return 1'b1;
            default: return a & ~b;
        endcase
    endfunction

    assign start0 = start && !sel;
    assign start1 = start && sel;
    always_comb dut_s0 = dut_fn(mode, int'(vec0));
    always_comb dut_s1 = dut_fn(mode, int'(vec1));

    truth_table_checker u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .dut_s(dut_s0),
        .vec_out(vec0), .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .first_fail_valid(ffv0), .first_fail_idx(ffi0),
        .sample_strobe(stb0), .mismatch(mis0)
    );

    truth_table_checker #(.N_IN(2), .TRUTH(4'b0100), .SETTLE(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_s(dut_s1),
        .vec_out(vec1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .first_fail_valid(ffv1), .first_fail_idx(ffi1),
        .sample_strobe(stb1), .mismatch(mis1)
    );

    logic [1:0] s_vec, s_ffi;
    logic [2:0] s_err;
    logic       s_busy, s_done, s_pass, s_ffv, s_stb, s_mis;
    assign s_vec  = sel ? vec1  : vec0;
    assign s_ffi  = sel ? ffi1  : ffi0;
    assign s_err  = sel ? err1  : err0;
    assign s_busy = sel ? busy1 : busy0;
    assign s_done = sel ? done1 : done0;
    assign s_pass = sel ? pass1 : pass0;
    assign s_ffv  = sel ? ffv1  : ffv0;
    assign s_stb  = sel ? stb1  : stb0;
    assign s_mis  = sel ? mis1  : mis0;

    typedef struct {
        logic [1:0] idx;
        logic       m;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_u0"}, {vec0, busy0, done0, pass0, err0, ffv0, ffi0, stb0, mis0}, 0);
        chk({tag, "_u1"}, {vec1, busy1, done1, pass1, err1, ffv1, ffi1, stb1, mis1}, 0);
    endtask

    // smode: 0 single start pulse, 1 start held high, 2 start toggling.
    // abort_at: cycle at which rst_n is pulled low mid-cycle (-1 = never).
    task automatic sweep(input int s, input int m, input int smode, input int abort_at);
        int         c, j, nexp;
        logic       fvalid, fin;
        logic [1:0] fidx;
        exp_t       e;
        q.delete();
        nexp   = 0;
        fvalid = 1'b0;
        fidx   = 2'd0;
        mode   = m;
        for (int v = 0; v < 4; v++) begin
            logic mm;
            mm = (dut_fn(m, v) != good_s(v));
            q.push_back('{idx: v[1:0], m: mm});
            if (mm) begin
                nexp++;
                if (!fvalid) begin
                    fvalid = 1'b1;
                    fidx   = v[1:0];
                end
            end
        end
        start = 1'b1;
        @(posedge clk);
        c   = 0;
        j   = 0;
        fin = 1'b0;
        while (!fin && c < 60) begin
            @(negedge clk);
            if (smode == 0) start = 1'b0;
            else if (smode == 2) start = c[0];
            if (c == 0) begin
                chk("accept_busy", s_busy, 1);
                chk("accept_cleared", {s_done, s_pass, s_err, s_ffv, s_ffi}, 0);
                chk("accept_vec", s_vec, 0);
            end
            if (c == abort_at) begin
                #1 rst_n = 1'b0;
                #1 chk_all_zero("async_reset");
                start = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                chk_all_zero("after_release");
                return;
            end
            if (s_stb) begin
                if (q.size() == 0) begin
                    chk("extra_strobe", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("strobe_vec", s_vec, e.idx);
                    chk("strobe_mismatch", s_mis, e.m);
                    chk("strobe_cycle", c, j * (s + 2) + s + 1);
                    j++;
                end
            end else if (s_mis) begin
                chk("mismatch_without_strobe", s_mis, 0);
            end
            if (s_done) begin
                fin   = 1'b1;
                start = 1'b0;
                chk("done_cycle", c, 4 * (s + 2));
                chk("done_busy", s_busy, 0);
                chk("pass", s_pass, (nexp == 0));
                chk("err_cnt", s_err, nexp);
                chk("first_fail_valid", s_ffv, fvalid);
                if (fvalid) chk("first_fail_idx", s_ffi, fidx);
                chk("done_vec", s_vec, 3);
                chk("all_vectors_sampled", q.size(), 0);
            end
            c++;
        end
        chk("sweep_finished", fin, 1);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sel   = 1'b0;
        mode  = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        // Correct DUT, then faulty a|b, then hold-in-DONE check.
        sweep(1, 0, 0, -1);
        sweep(1, 1, 0, -1);
        repeat (3) @(negedge clk);
        chk("done_hold", {s_done, s_vec, s_err, s_pass}, {1'b1, 2'd3, 3'd2, 1'b0});

        // Restart from DONE after a faulty run with a correct DUT.
        sweep(1, 0, 0, -1);

        // SETTLE=0 instance with a stuck-at-1 DUT.
        sel = 1'b1;
        @(negedge clk);
        sweep(0, 2, 0, -1);

        // Start held high, then start toggling during a faulty sweep.
        sel = 1'b0;
        @(negedge clk);
        sweep(1, 0, 1, -1);
        sweep(1, 1, 2, -1);

        // Reset at cycle 3 of a faulty sweep, then a fresh full sweep.
        sweep(1, 1, 0, 3);
        sweep(1, 1, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
